// File: rtl/regbank_pkg.sv
// Shared constants, write-request payload and arbiter state encoding for the
// register-bank write arbiter.
package regbank_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned NUM_REGS   = 1 << ADDR_W;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic {
    PRIO0 = 1'b0,
    PRIO1 = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regbank_wr_fifo.sv
// In-order request FIFO with async-reset pointers/count; exposes per-entry
// valid and address vectors so the top can build the pending mask.
module regbank_wr_fifo
  import regbank_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  wr_req_t                      push_data_i,
  input  logic                         pop_i,
  output wr_req_t                      head_o,
  output logic [CW-1:0]                count_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [DEPTH-1:0]             valid_vec_o,
  output logic [DEPTH-1:0][ADDR_W-1:0] addr_vec_o
);

  wr_req_t        mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: entries are qualified by valid_vec_o.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Entry i is live when its distance from the read pointer is below count.
  always_comb begin
    valid_vec_o = '0;
    addr_vec_o  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      int unsigned off;
      off            = (i + DEPTH - 32'(rd_ptr_q)) % DEPTH;
      valid_vec_o[i] = (off < 32'(count_q));
      addr_vec_o[i]  = mem_q[i].addr;
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port between the ALU
// and load writeback paths, with a registered write stage and pending mask.
module regbank_write_arbiter
  import regbank_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                RegWrite,
  output logic [ADDR_W-1:0]   WriteReg,
  output logic [DATA_W-1:0]   WriteData,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [CNT_W-1:0]    fifo0_count,
  output logic [CNT_W-1:0]    fifo1_count
);

  wr_req_t                          head0, head1;
  logic                             full0, full1, empty0, empty1;
  logic                             grant0, grant1;
  logic [FIFO_DEPTH-1:0]            vld0, vld1;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] adr0, adr1;

  arb_state_e        state_q, state_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Ready depends only on occupancy, never on a same-cycle pop.
  assign req0_ready = ~reset & ~full0;
  assign req1_ready = ~reset & ~full1;

  regbank_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (req0_valid & req0_ready),
    .push_data_i ({req0_addr, req0_data}),
    .pop_i       (grant0),
    .head_o      (head0),
    .count_o     (fifo0_count),
    .full_o      (full0),
    .empty_o     (empty0),
    .valid_vec_o (vld0),
    .addr_vec_o  (adr0)
  );

  regbank_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (req1_valid & req1_ready),
    .push_data_i ({req1_addr, req1_data}),
    .pop_i       (grant1),
    .head_o      (head1),
    .count_o     (fifo1_count),
    .full_o      (full1),
    .empty_o     (empty1),
    .valid_vec_o (vld1),
    .addr_vec_o  (adr1)
  );

  // Arbitration and write-stage next state.
  always_comb begin
    state_d    = state_q;
    grant0     = 1'b0;
    grant1     = 1'b0;
    regwrite_d = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (!empty0 && (empty1 || state_q == PRIO0)) begin
      grant0 = 1'b1;
    end else if (!empty1) begin
      grant1 = 1'b1;
    end
    if (grant0) begin
      state_d    = PRIO1;
      regwrite_d = 1'b1;
      waddr_d    = head0.addr;
      wdata_d    = head0.data;
    end else if (grant1) begin
      state_d    = PRIO0;
      regwrite_d = 1'b1;
      waddr_d    = head1.addr;
      wdata_d    = head1.data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= PRIO0;
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      regwrite_q <= regwrite_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign RegWrite  = regwrite_q;
  assign WriteReg  = waddr_q;
  assign WriteData = wdata_q;

  // Any queued entry or the issuing write marks its target register busy.
  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (vld0[i]) pending_mask[adr0[i]] = 1'b1;
      if (vld1[i]) pending_mask[adr1[i]] = 1'b1;
    end
    if (regwrite_q) pending_mask[waddr_q] = 1'b1;
  end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed self-checking bench for regbank_write_arbiter.
module tb_regbank_write_arbiter;

  logic        clock;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_addr, req1_addr;
  logic [15:0] req0_data, req1_data;
  logic        RegWrite;
  logic [2:0]  WriteReg;
  logic [15:0] WriteData;
  logic [7:0]  pending_mask;
  logic [1:0]  fifo0_count, fifo1_count;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  regbank_write_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_addr    (req0_addr),
    .req0_data    (req0_data),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_addr    (req1_addr),
    .req1_data    (req1_data),
    .RegWrite     (RegWrite),
    .WriteReg     (WriteReg),
    .WriteData    (WriteData),
    .pending_mask (pending_mask),
    .fifo0_count  (fifo0_count),
    .fifo1_count  (fifo1_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Expected per-edge results for both requesters flooding for six edges.
  int exp_rw [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int exp_wr [10] = '{0, 1, 2, 1, 2, 1, 2, 1, 2, 2};
  int exp_c0 [10] = '{1, 1, 2, 1, 2, 1, 1, 0, 0, 0};
  int exp_c1 [10] = '{1, 2, 1, 2, 1, 2, 1, 1, 0, 0};

  initial begin
    int wd;
    reset = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    tick();
    tick();
    check("rst_regwrite", 32'(RegWrite), 0);
    check("rst_mask",     32'(pending_mask), 0);
    check("rst_ready0",   32'(req0_ready), 0);
    check("rst_ready1",   32'(req1_ready), 0);
    check("rst_cnt0",     32'(fifo0_count), 0);
    check("rst_wreg",     32'(WriteReg), 0);
    reset = 1'b0;
    #1;
    check("rel_ready0", 32'(req0_ready), 1);

    // Single write: latency and pending mask lifetime.
    req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 16'hBEEF;
    tick();
    req0_valid = 1'b0;
    check("single_mask_q",  32'(pending_mask), 32'h08);
    check("single_cnt0",    32'(fifo0_count), 1);
    check("single_rw_early", 32'(RegWrite), 0);
    tick();
    check("single_rw",   32'(RegWrite), 1);
    check("single_wreg", 32'(WriteReg), 3);
    check("single_wdat", 32'(WriteData), 32'hBEEF);
    check("single_mask_issue", 32'(pending_mask), 32'h08);
    tick();
    check("single_rw_off", 32'(RegWrite), 0);
    check("single_mask_clr", 32'(pending_mask), 0);
    check("single_wreg_hold", 32'(WriteReg), 3);

    // Both requesters saturated: strict alternation starting with 0.
    do_reset();
    req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 16'hA000;
    req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 16'hB000;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 5) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      wd = (exp_wr[i] == 1) ? 32'hA000 : (exp_wr[i] == 2) ? 32'hB000 : 0;
      check($sformatf("alt_rw[%0d]", i),   32'(RegWrite), 32'(exp_rw[i]));
      check($sformatf("alt_wreg[%0d]", i), 32'(WriteReg), 32'(exp_wr[i]));
      check($sformatf("alt_wdat[%0d]", i), 32'(WriteData), 32'(wd));
      check($sformatf("alt_cnt0[%0d]", i), 32'(fifo0_count), 32'(exp_c0[i]));
      check($sformatf("alt_cnt1[%0d]", i), 32'(fifo1_count), 32'(exp_c1[i]));
      check($sformatf("alt_rdy0[%0d]", i), 32'(req0_ready), (exp_c0[i] < 2) ? 1 : 0);
      check($sformatf("alt_rdy1[%0d]", i), 32'(req1_ready), (exp_c1[i] < 2) ? 1 : 0);
    end
    check("alt_mask_end", 32'(pending_mask), 0);

    // req1 alone streams three writes without stalling.
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req1_addr = 3'(4 + i);
      req1_data = 16'(i + 1);
      check($sformatf("r1_ready[%0d]", i), 32'(req1_ready), 1);
      tick();
    end
    req1_valid = 1'b0;
    check("r1_wreg_a", 32'(WriteReg), 5);
    check("r1_wdat_a", 32'(WriteData), 2);
    check("r1_cnt",    32'(fifo1_count), 1);
    tick();
    check("r1_rw_b",   32'(RegWrite), 1);
    check("r1_wreg_b", 32'(WriteReg), 6);
    check("r1_wdat_b", 32'(WriteData), 3);
    tick();
    check("r1_rw_off", 32'(RegWrite), 0);

    // Same-address conflict in PRIO0: bank sees req0's value, then req1's.
    req0_valid = 1'b1; req0_addr = 3'd5; req0_data = 16'd1;
    req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 16'd2;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("conf_mask0", 32'(pending_mask), 32'h20);
    tick();
    check("conf_rw1",   32'(RegWrite), 1);
    check("conf_wdat1", 32'(WriteData), 1);
    check("conf_mask1", 32'(pending_mask), 32'h20);
    tick();
    check("conf_rw2",   32'(RegWrite), 1);
    check("conf_wreg2", 32'(WriteReg), 5);
    check("conf_wdat2", 32'(WriteData), 2);
    check("conf_mask2", 32'(pending_mask), 32'h20);
    tick();
    check("conf_mask3", 32'(pending_mask), 0);

    // Reset mid-operation with entries queued on both sides.
    req0_valid = 1'b1; req0_addr = 3'd6; req0_data = 16'h0066;
    req1_valid = 1'b1; req1_addr = 3'd7; req1_data = 16'h0077;
    tick();
    tick();
    tick();
    check("mid_rw_pre",   32'(RegWrite), 1);
    check("mid_wreg_pre", 32'(WriteReg), 7);
    check("mid_cnt0_pre", 32'(fifo0_count), 2);
    check("mid_cnt1_pre", 32'(fifo1_count), 1);
    #1;
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("mid_rw",   32'(RegWrite), 0);
    check("mid_cnt0", 32'(fifo0_count), 0);
    check("mid_cnt1", 32'(fifo1_count), 0);
    check("mid_mask", 32'(pending_mask), 0);
    check("mid_rdy0", 32'(req0_ready), 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post_rw[%0d]", i),   32'(RegWrite), 0);
      check($sformatf("post_mask[%0d]", i), 32'(pending_mask), 0);
    end

    // Back-to-back req0 writes to every register, in order.
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        req0_valid = 1'b1;
        req0_addr  = 3'(i);
        req0_data  = 16'(i * 16'h11);
      end else begin
        req0_valid = 1'b0;
      end
      tick();
      if (i == 0) check("seq_mask0", 32'(pending_mask), 32'h01);
      if (i >= 1 && i <= 8) begin
        check($sformatf("seq_rw[%0d]", i - 1),   32'(RegWrite), 1);
        check($sformatf("seq_wreg[%0d]", i - 1), 32'(WriteReg), 32'(i - 1));
        check($sformatf("seq_wdat[%0d]", i - 1), 32'(WriteData), 32'((i - 1) * 16'h11));
      end
      if (i == 9) check("seq_rw_off", 32'(RegWrite), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
